// File: rtl/rc5_keyex_if.sv
// rc5_keyex_if: key-load strobe and expanded-table bus between the key source, rc5_keyex and the RC5 data path
interface rc5_keyex_if;
  logic [127:0] i_key;
  logic         i_key_en;
  logic [831:0] o_keyex;
  logic         o_keyex_en;
  logic         o_key_ok;
  logic         o_busy;
  modport master (output i_key, i_key_en, input o_keyex, o_keyex_en, o_key_ok, o_busy);
  modport slave (input i_key, i_key_en, output o_keyex, o_keyex_en, o_key_ok, o_busy);
endinterface

// File: rtl/rc5_keyex.sv
// rc5_keyex: RC5-32/12/16 key expansion, one mixing iteration per clock, table held until the next load
module rc5_keyex #(
  parameter logic [31:0] P32 = 32'hB7E15163,
  parameter logic [31:0] Q32 = 32'h9E3779B9
) (
  input logic        i_clk,
  input logic        i_rst,
  rc5_keyex_if.slave bus
);
  typedef enum logic [1:0] {IDLE, MIX, DONE} state_t;
  state_t st;
  logic [31:0] s [26];
  logic [31:0] l [4];
  logic [31:0] a, b, sa, sb, lb, a_n, b_n;
  logic [63:0] ra, rb;
  logic [4:0] i;
  logic [1:0] j;
  logic [6:0] cnt;
  logic keyex_en, key_ok, busy;
  function automatic logic [31:0] swap32(input logic [31:0] w);
    return {w[7:0], w[15:8], w[23:16], w[31:24]};
  endfunction
  // A' feeds B' in the same cycle; a doubled word shifted left yields the rotate in its upper half
  always_comb begin
    sa = s[i] + a + b;
    ra = {sa, sa} << 3;
    a_n = ra[63:32];
    sb = a_n + b;
    lb = l[j] + sb;
    rb = {lb, lb} << sb[4:0];
    b_n = rb[63:32];
  end
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      st <= IDLE;
      for (int n = 0; n < 26; n++) s[n] <= '0;
      for (int n = 0; n < 4; n++) l[n] <= '0;
      a <= '0;
      b <= '0;
      i <= '0;
      j <= '0;
      cnt <= '0;
      keyex_en <= 1'b0;
      key_ok <= 1'b0;
      busy <= 1'b0;
    end else begin
      keyex_en <= 1'b0;
      if (bus.i_key_en) begin
        for (int n = 0; n < 4; n++) l[n] <= swap32(bus.i_key[127-32*n -: 32]);
        for (int n = 0; n < 26; n++) s[n] <= P32 + Q32 * 32'(n);
        a <= '0;
        b <= '0;
        i <= '0;
        j <= '0;
        cnt <= '0;
        st <= MIX;
        busy <= 1'b1;
        key_ok <= 1'b0;
      end else if (st == MIX) begin
        s[i] <= a_n;
        l[j] <= b_n;
        a <= a_n;
        b <= b_n;
        i <= (i == 5'd25) ? 5'd0 : i + 5'd1;
        j <= (j == 2'd3) ? 2'd0 : j + 2'd1;
        cnt <= cnt + 7'd1;
        if (cnt == 7'd77) begin
          st <= DONE;
          busy <= 1'b0;
          key_ok <= 1'b1;
          keyex_en <= 1'b1;
        end
      end
    end
  end
  for (genvar g = 0; g < 26; g++) assign bus.o_keyex[32*(26-g)-1 -: 32] = s[g];
  assign bus.o_keyex_en = keyex_en;
  assign bus.o_key_ok = key_ok;
  assign bus.o_busy = busy;
endmodule

// File: tb/tb_rc5_keyex.sv
// tb_rc5_keyex: directed checks of rc5_keyex latency, known-answer vectors, abort, reset and hold behaviour
module tb_rc5_keyex;
  localparam logic [31:0] P = 32'hB7E15163;
  localparam logic [31:0] Q = 32'h9E3779B9;
  localparam logic [127:0] K2 = 128'h915F4619BE41B2516355A50110A9CE91;
  localparam logic [127:0] KX = 128'h0123456789ABCDEFFEDCBA9876543210;
  localparam logic [127:0] KY = 128'hDEADBEEF00112233445566778899AABB;
  logic clk = 1'b0;
  logic rst = 1'b0;
  int checks = 0;
  int errors = 0;
  rc5_keyex_if bus ();
  rc5_keyex dut (.i_clk(clk), .i_rst(rst), .bus(bus));
  always #5 clk = ~clk;

  function automatic logic [31:0] rl(input logic [31:0] x, input logic [4:0] s);
    return (s == 5'd0) ? x : ((x << s) | (x >> (6'd32 - {1'b0, s})));
  endfunction
  function automatic logic [31:0] sw(input logic [31:0] x);
    return {x[7:0], x[15:8], x[23:16], x[31:24]};
  endfunction
  function automatic logic [31:0] wd(input logic [831:0] t, input int n);
    return t[32*(25-n) +: 32];
  endfunction
  function automatic logic [831:0] model(input logic [127:0] key);
    logic [31:0] S [26];
    logic [31:0] L [4];
    logic [31:0] A, B, t;
    logic [831:0] r;
    int ii, jj;
    for (int k = 0; k < 4; k++) L[k] = sw(key[127-32*k -: 32]);
    S[0] = P;
    for (int n = 1; n < 26; n++) S[n] = S[n-1] + Q;
    A = 0; B = 0; ii = 0; jj = 0;
    for (int k = 0; k < 78; k++) begin
      A = rl(S[ii] + A + B, 5'd3);
      S[ii] = A;
      t = A + B;
      B = rl(L[jj] + t, t[4:0]);
      L[jj] = B;
      ii = (ii + 1) % 26;
      jj = (jj + 1) % 4;
    end
    for (int n = 0; n < 26; n++) r[32*(25-n) +: 32] = S[n];
    return r;
  endfunction
  function automatic logic [63:0] enc(input logic [831:0] t, input logic [63:0] pt);
    logic [31:0] A, B;
    A = sw(pt[63:32]) + wd(t, 0);
    B = sw(pt[31:0]) + wd(t, 1);
    for (int r = 1; r <= 12; r++) begin
      A = rl(A ^ B, B[4:0]) + wd(t, 2*r);
      B = rl(B ^ A, A[4:0]) + wd(t, 2*r+1);
    end
    return {sw(A), sw(B)};
  endfunction
  function automatic logic [63:0] dec(input logic [831:0] t, input logic [63:0] ct);
    logic [31:0] A, B;
    A = sw(ct[63:32]);
    B = sw(ct[31:0]);
    for (int r = 12; r >= 1; r--) begin
      B = rl(B - wd(t, 2*r+1), 5'd0 - A[4:0]) ^ A;
      A = rl(A - wd(t, 2*r), 5'd0 - B[4:0]) ^ B;
    end
    B = B - wd(t, 1);
    A = A - wd(t, 0);
    return {sw(A), sw(B)};
  endfunction

  task automatic tick;
    @(posedge clk);
    #1;
  endtask
  task automatic pulse(input logic [127:0] key);
    bus.i_key = key;
    bus.i_key_en = 1'b1;
    tick;
    bus.i_key_en = 1'b0;
  endtask
  task automatic wait_done(output int n);
    n = 1;
    while (!bus.o_keyex_en && n < 200) begin
      tick;
      n++;
    end
  endtask

  task automatic test_reset;
    rst = 1'b1;
    bus.i_key = '1;
    bus.i_key_en = 1'b1;
    tick;
    tick;
    rst = 1'b0;
    bus.i_key_en = 1'b0;
    checks += 4;
    if (bus.o_keyex !== '0) begin errors++; $display("FAIL reset_keyex got %h want 0", bus.o_keyex); end
    if (bus.o_keyex_en !== 1'b0) begin errors++; $display("FAIL reset_keyex_en got %b want 0", bus.o_keyex_en); end
    if (bus.o_key_ok !== 1'b0) begin errors++; $display("FAIL reset_key_ok got %b want 0", bus.o_key_ok); end
    if (bus.o_busy !== 1'b0) begin errors++; $display("FAIL reset_busy got %b want 0 (reset must beat key_en)", bus.o_busy); end
    tick;
    checks++;
    if (bus.o_busy !== 1'b0) begin errors++; $display("FAIL reset_idle_busy got %b want 0", bus.o_busy); end
  endtask

  task automatic test_latency;
    logic [63:0] ct;
    pulse('0);
    for (int c = 1; c <= 78; c++) begin
      checks += 3;
      if (bus.o_busy !== 1'b1) begin errors++; $display("FAIL lat_busy c=%0d got %b want 1", c, bus.o_busy); end
      if (bus.o_keyex_en !== 1'b0) begin errors++; $display("FAIL lat_en_early c=%0d got %b want 0", c, bus.o_keyex_en); end
      if (bus.o_key_ok !== 1'b0) begin errors++; $display("FAIL lat_ok_early c=%0d got %b want 0", c, bus.o_key_ok); end
      tick;
    end
    checks += 3;
    if (bus.o_keyex_en !== 1'b1) begin errors++; $display("FAIL lat_en_79 got %b want 1", bus.o_keyex_en); end
    if (bus.o_key_ok !== 1'b1) begin errors++; $display("FAIL lat_ok_79 got %b want 1", bus.o_key_ok); end
    if (bus.o_busy !== 1'b0) begin errors++; $display("FAIL lat_busy_79 got %b want 0", bus.o_busy); end
    tick;
    checks += 2;
    if (bus.o_keyex_en !== 1'b0) begin errors++; $display("FAIL lat_en_80 got %b want 0", bus.o_keyex_en); end
    if (bus.o_key_ok !== 1'b1) begin errors++; $display("FAIL lat_ok_80 got %b want 1", bus.o_key_ok); end
    ct = enc(bus.o_keyex, 64'h0);
    checks += 3;
    if (ct !== 64'h21A5DBEE154B8F6D) begin errors++; $display("FAIL zero_key_enc got %h want 21a5dbee154b8f6d", ct); end
    if (dec(bus.o_keyex, 64'h21A5DBEE154B8F6D) !== 64'h0) begin errors++; $display("FAIL zero_key_dec got %h want 0", dec(bus.o_keyex, 64'h21A5DBEE154B8F6D)); end
    if (bus.o_keyex !== model('0)) begin errors++; $display("FAIL zero_key_table got %h want %h", bus.o_keyex, model('0)); end
  endtask

  task automatic test_second;
    int n;
    logic [831:0] exp;
    logic [63:0] ct;
    pulse(K2);
    checks += 2;
    if (bus.o_key_ok !== 1'b0) begin errors++; $display("FAIL reload_ok_drop got %b want 0", bus.o_key_ok); end
    if (bus.o_busy !== 1'b1) begin errors++; $display("FAIL reload_busy got %b want 1", bus.o_busy); end
    wait_done(n);
    checks++;
    if (n !== 79) begin errors++; $display("FAIL second_latency got %0d want 79", n); end
    exp = model(K2);
    for (int k = 0; k < 26; k++) begin
      checks++;
      if (wd(bus.o_keyex, k) !== wd(exp, k)) begin errors++; $display("FAIL second_S%0d got %h want %h", k, wd(bus.o_keyex, k), wd(exp, k)); end
    end
    ct = enc(bus.o_keyex, 64'h21A5DBEE154B8F6D);
    checks++;
    if (ct !== 64'hF7C013AC5B2B8952) begin errors++; $display("FAIL second_enc got %h want f7c013ac5b2b8952", ct); end
  endtask

  task automatic test_abort;
    int n, first;
    n = 0;
    first = 0;
    pulse(KX);
    for (int c = 0; c < 39; c++) begin
      if (bus.o_keyex_en) n++;
      tick;
    end
    pulse(KY);
    for (int c = 1; c <= 100; c++) begin
      if (bus.o_keyex_en) begin
        n++;
        if (first == 0) first = c;
      end
      tick;
    end
    checks += 4;
    if (n !== 1) begin errors++; $display("FAIL abort_pulses got %0d want 1", n); end
    if (first !== 79) begin errors++; $display("FAIL abort_latency got %0d want 79", first); end
    if (bus.o_keyex !== model(KY)) begin errors++; $display("FAIL abort_table got %h want %h", bus.o_keyex, model(KY)); end
    if (bus.o_key_ok !== 1'b1) begin errors++; $display("FAIL abort_ok got %b want 1", bus.o_key_ok); end
  endtask

  task automatic test_reset_mid;
    int n;
    n = 0;
    pulse(K2);
    for (int c = 0; c < 29; c++) tick;
    rst = 1'b1;
    tick;
    rst = 1'b0;
    checks += 4;
    if (bus.o_busy !== 1'b0) begin errors++; $display("FAIL midrst_busy got %b want 0", bus.o_busy); end
    if (bus.o_key_ok !== 1'b0) begin errors++; $display("FAIL midrst_ok got %b want 0", bus.o_key_ok); end
    if (bus.o_keyex !== '0) begin errors++; $display("FAIL midrst_keyex got %h want 0", bus.o_keyex); end
    if (bus.o_keyex_en !== 1'b0) begin errors++; $display("FAIL midrst_en got %b want 0", bus.o_keyex_en); end
    for (int c = 0; c < 100; c++) begin
      if (bus.o_keyex_en) n++;
      tick;
    end
    checks += 2;
    if (n !== 0) begin errors++; $display("FAIL midrst_pulses got %0d want 0", n); end
    if (bus.o_busy !== 1'b0) begin errors++; $display("FAIL midrst_idle_busy got %b want 0", bus.o_busy); end
  endtask

  task automatic test_hold;
    int n;
    logic [831:0] exp;
    exp = model(K2);
    pulse(K2);
    wait_done(n);
    checks++;
    if (n !== 79) begin errors++; $display("FAIL hold_latency got %0d want 79", n); end
    tick;
    for (int c = 0; c < 200; c++) begin
      bus.i_key = {$urandom, $urandom, $urandom, $urandom};
      checks += 3;
      if (bus.o_keyex !== exp) begin errors++; $display("FAIL hold_table c=%0d got %h want %h", c, bus.o_keyex, exp); end
      if (bus.o_key_ok !== 1'b1) begin errors++; $display("FAIL hold_ok c=%0d got %b want 1", c, bus.o_key_ok); end
      if (bus.o_keyex_en !== 1'b0) begin errors++; $display("FAIL hold_en c=%0d got %b want 0", c, bus.o_keyex_en); end
      tick;
    end
  endtask

  initial begin
    bus.i_key = '0;
    bus.i_key_en = 1'b0;
    test_reset;
    test_latency;
    test_second;
    test_abort;
    test_reset_mid;
    test_hold;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
